// File: rtl/adc_capture_buf.sv
// Triggered multi-channel ADC capture buffer: arm/trigger capture of whole frames
// into a frame memory, then readout of enabled channels as a valid/ready stream.
module adc_capture_buf #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int CH_W   = ($clog2(NUM_CH) > 0 ? $clog2(NUM_CH) : 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [CNT_W-1:0]         cap_len,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     abort,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CH_W-1:0]          rd_ch,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err_trig
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME_W = NUM_CH * DATA_W;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    rd_frame;
  logic [CH_W-1:0]     rd_chn;
  logic [CH_W-1:0]     first_q;
  logic                rd_issued;
  logic [FRAME_W-1:0]  mem [DEPTH];

  // Lowest enabled channel at or above start; MSB flags whether one exists.
  function automatic logic [CH_W:0] find_en(input logic [NUM_CH-1:0] mask, input int start);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  logic [CH_W:0]    arm_first;
  logic [CH_W:0]    nxt_ch;
  logic [CNT_W-1:0] arm_len;
  logic [CNT_W-1:0] wr_next;
  logic             cap_we;
  logic             issue;
  logic             frame_end;
  logic             last_word;
  logic             xfer;

  assign arm_first = find_en(ch_en, 0);
  assign nxt_ch    = find_en(mask_q, int'(rd_chn) + 1);
  assign arm_len   = (cap_len == '0 || cap_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cap_len;
  assign wr_next   = wr_ptr + CNT_W'(1);
  assign cap_we    = !abort && adc_valid && ((state == ARMED && trig) || state == CAPTURE);
  // A new word is loaded whenever the output register is empty or being drained.
  assign issue     = state == READOUT && !rd_issued && (!rd_valid || rd_ready);
  assign frame_end = !nxt_ch[CH_W];
  assign last_word = frame_end && (rd_frame == len_q - CNT_W'(1));
  assign xfer      = rd_valid && rd_ready;
  assign busy      = (state != IDLE);

  // NOTE: the frame memory has no reset so it can map onto RAM; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (cap_we) mem[wr_ptr[ADDR_W-1:0]] <= adc_data;
  end

  // NOTE: every register here uses <= so all reads see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      len_q     <= '0;
      wr_ptr    <= '0;
      rd_frame  <= '0;
      rd_chn    <= '0;
      first_q   <= '0;
      rd_issued <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_ch     <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err_trig  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        rd_valid  <= 1'b0;
        rd_last   <= 1'b0;
        wr_ptr    <= '0;
        rd_frame  <= '0;
        rd_chn    <= '0;
        rd_issued <= 1'b0;
      end else begin
        if (trig && (state == CAPTURE || state == READOUT)) err_trig <= 1'b1;
        case (state)
          IDLE: begin
            if (arm && arm_first[CH_W]) begin
              mask_q   <= ch_en;
              len_q    <= arm_len;
              first_q  <= arm_first[CH_W-1:0];
              rd_chn   <= arm_first[CH_W-1:0];
              err_trig <= 1'b0;
              wr_ptr   <= '0;
              state    <= ARMED;
            end
          end
          ARMED: begin
            if (trig) begin
              state <= (cap_we && wr_next == len_q) ? READOUT : CAPTURE;
              if (cap_we) wr_ptr <= wr_next;
            end
          end
          CAPTURE: begin
            if (cap_we) begin
              wr_ptr <= wr_next;
              if (wr_next == len_q) state <= READOUT;
            end
          end
          READOUT: begin
            if (issue) begin
              rd_valid <= 1'b1;
              rd_data  <= mem[rd_frame[ADDR_W-1:0]][rd_chn*DATA_W +: DATA_W];
              rd_ch    <= rd_chn;
              rd_last  <= last_word;
              if (last_word) rd_issued <= 1'b1;
              if (frame_end) begin
                rd_chn   <= first_q;
                rd_frame <= rd_frame + CNT_W'(1);
              end else begin
                rd_chn <= nxt_ch[CH_W-1:0];
              end
            end
            if (xfer && rd_last) begin
              state     <= IDLE;
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              done      <= 1'b1;
              wr_ptr    <= '0;
              rd_frame  <= '0;
              rd_chn    <= '0;
              rd_issued <= 1'b0;
            end else if (xfer && !issue) begin
              rd_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_buf.sv
// Bench for adc_capture_buf: a queue-based model of the expected readout stream,
// checked every cycle, plus directed arm/trigger/abort/reset scenarios.
module tb_adc_capture_buf;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] adc_data;
  logic                     adc_valid;
  logic [NUM_CH-1:0]        ch_en;
  logic [CNT_W-1:0]         cap_len;
  logic                     arm;
  logic                     trig;
  logic                     abort;
  logic                     rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic [CH_W-1:0]          rd_ch;
  logic                     rd_last;
  logic                     rd_ready;
  logic                     busy;
  logic                     done;
  logic                     err_trig;

  adc_capture_buf #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .ch_en(ch_en), .cap_len(cap_len), .arm(arm), .trig(trig), .abort(abort),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last),
    .rd_ready(rd_ready), .busy(busy), .done(done), .err_trig(err_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic              last;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    ready_mode = 0;
  bit    chk_en = 1'b0;
  bit    done_seen = 1'b0;
  int    xfer_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Sample word: {run, frame, channel}; frames past the memory depth are inverted
  // so a wrongly accepted extra frame cannot alias a legitimate one.
  function automatic logic [DATA_W-1:0] sample(input int run, input int f, input int k);
    logic [DATA_W-1:0] s;
    s = {2'(run), 6'(f), 4'(k)};
    if (f >= DEPTH) s = ~s;
    return s;
  endfunction

  task automatic build_expect(input int run, input logic [NUM_CH-1:0] mask, input int len);
    int hi;
    word_t w;
    hi = 0;
    for (int k = 0; k < NUM_CH; k++) if (mask[k]) hi = k;
    for (int f = 0; f < len; f++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (mask[k]) begin
          w.data = sample(run, f, k);
          w.ch   = CH_W'(k);
          w.last = (f == len - 1) && (k == hi);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Stream checker: every transfer is matched against the model queue, stalled
  // words must hold, and done must follow the rd_last transfer by exactly one cycle.
  initial begin
    logic              exp_done;
    logic              hold_prev;
    logic [DATA_W-1:0] prev_data;
    logic [CH_W-1:0]   prev_ch;
    logic              prev_last;
    word_t             w;
    exp_done  = 1'b0;
    hold_prev = 1'b0;
    prev_data = '0;
    prev_ch   = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        exp_done  = 1'b0;
        hold_prev = 1'b0;
      end else begin
        check("done", done, exp_done);
        if (exp_done) begin
          done_seen = 1'b1;
          check("busy_at_done", busy, 0);
          check("valid_at_done", rd_valid, 0);
        end
        if (hold_prev) begin
          check("hold_valid", rd_valid, 1);
          check("hold_data", rd_data, prev_data);
          check("hold_ch", rd_ch, prev_ch);
          check("hold_last", rd_last, prev_last);
        end
        exp_done = rd_valid && rd_ready && rd_last;
        if (rd_valid && rd_ready) begin
          xfer_count++;
          if (exp_q.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            w = exp_q.pop_front();
            check("word_data", rd_data, w.data);
            check("word_ch", rd_ch, w.ch);
            check("word_last", rd_last, w.last);
          end
        end
        hold_prev = rd_valid && !rd_ready;
        prev_data = rd_data;
        prev_ch   = rd_ch;
        prev_last = rd_last;
      end
    end
  end

  task automatic do_arm(input logic [NUM_CH-1:0] mask, input int clen);
    @(posedge clk);
    #1;
    done_seen  = 1'b0;
    xfer_count = 0;
    ch_en      = mask;
    cap_len    = CNT_W'(clen);
    arm        = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic do_trig();
    @(posedge clk);
    #1;
    trig = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic send_frames(input int run, input int first, input int n, input bit trig_first);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_CH; k++) adc_data[k*DATA_W +: DATA_W] = sample(run, first + i, k);
      adc_valid = 1'b1;
      trig      = trig_first && (i == 0);
    end
    @(posedge clk);
    #1;
    adc_valid = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done_seen && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("done_timeout", done_seen, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    adc_data  = '0;
    adc_valid = 1'b0;
    ch_en     = '0;
    cap_len   = '0;
    arm       = 1'b0;
    trig      = 1'b0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_ch", rd_ch, 0);
    check("rst_last", rd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_trig, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full mask, three frames, frame 0 arriving with the trigger.
    ready_mode = 0;
    do_arm(4'b1111, 3);
    @(negedge clk);
    check("t1_busy_armed", busy, 1);
    build_expect(0, 4'b1111, 3);
    check("t1_nwords", exp_q.size(), 12);
    check("t1_w0", exp_q[0].data, 12'h000);
    check("t1_w10_last", exp_q[10].last, 0);
    check("t1_w11", {exp_q[11].data, exp_q[11].ch, exp_q[11].last}, {12'h023, 2'd3, 1'b1});
    send_frames(0, 0, 3, 1'b1);
    wait_done(100);
    check("t1_xfers", xfer_count, 12);

    // Sparse mask with a toggling downstream ready.
    ready_mode = 1;
    do_arm(4'b0101, 2);
    build_expect(1, 4'b0101, 2);
    check("t2_nwords", exp_q.size(), 4);
    check("t2_w1_ch", exp_q[1].ch, 2);
    check("t2_w3", exp_q[3].data, 12'h412);
    do_trig();
    send_frames(1, 0, 2, 1'b0);
    wait_done(100);
    check("t2_xfers", xfer_count, 4);

    // Zero and oversize lengths both mean a full-depth capture.
    ready_mode = 0;
    do_arm(4'b0001, 0);
    build_expect(2, 4'b0001, DEPTH);
    check("t3a_nwords", exp_q.size(), 64);
    do_trig();
    send_frames(2, 0, DEPTH, 1'b0);
    wait_done(300);
    check("t3a_xfers", xfer_count, 64);

    do_arm(4'b0110, DEPTH + 5);
    build_expect(3, 4'b0110, DEPTH);
    check("t3b_nwords", exp_q.size(), 128);
    check("t3b_wlast", {exp_q[127].data, exp_q[127].ch, exp_q[127].last}, {12'hFF2, 2'd2, 1'b1});
    do_trig();
    send_frames(3, 0, DEPTH + 5, 1'b0);
    wait_done(400);
    check("t3b_xfers", xfer_count, 128);

    // Stray triggers during capture and readout raise the sticky error only.
    do_arm(4'b0011, 4);
    build_expect(0, 4'b0011, 4);
    do_trig();
    send_frames(0, 0, 2, 1'b0);
    @(negedge clk);
    check("t4_err_before", err_trig, 0);
    do_trig();
    @(negedge clk);
    check("t4_err_capture", err_trig, 1);
    send_frames(0, 2, 2, 1'b0);
    do_trig();
    @(negedge clk);
    check("t4_err_readout", err_trig, 1);
    wait_done(100);
    check("t4_err_held", err_trig, 1);
    check("t4_xfers", xfer_count, 8);

    // Abort mid-capture, then a short clean run.
    do_arm(4'b1111, 5);
    @(negedge clk);
    check("t5_err_cleared", err_trig, 0);
    do_trig();
    send_frames(1, 0, 2, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_valid", rd_valid, 0);
    repeat (5) @(posedge clk);
    check("t5_no_done", done_seen, 0);
    do_arm(4'b1000, 1);
    build_expect(2, 4'b1000, 1);
    check("t5_w0", {exp_q[0].data, exp_q[0].ch, exp_q[0].last}, {12'h803, 2'd3, 1'b1});
    do_trig();
    send_frames(2, 0, 1, 1'b0);
    wait_done(100);
    check("t5_xfers", xfer_count, 1);

    // Asynchronous reset while a word is waiting on a stalled downstream.
    ready_mode = 2;
    do_arm(4'b1111, 2);
    build_expect(3, 4'b1111, 2);
    do_trig();
    send_frames(3, 0, 2, 1'b0);
    for (int c = 0; c < 20 && !rd_valid; c++) @(negedge clk);
    @(negedge clk);
    check("t6_valid_seen", rd_valid, 1);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid, 0);
    check("t6_rst_data", rd_data, 0);
    check("t6_rst_ch", rd_ch, 0);
    check("t6_rst_last", rd_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    chk_en     = 1'b1;
    ready_mode = 0;
    do_arm(4'b0000, 3);
    repeat (3) @(negedge clk);
    check("t6_arm_nomask_busy", busy, 0);
    check("t6_arm_nomask_valid", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
